// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Serial configuration-chain loader for the DSP logical tile. Accepts
// parallel configuration words over a valid/ready handshake, shifts them
// LSB-first into the tile's ccff chain with a qualified shift enable, and
// returns the bits falling out of ccff_tail as a readback stream.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic              rb_bit,
    output logic              busy,
    output logic              done
);

    // Per-word bit counter must be able to hold the value WORD_W itself.
    localparam int BIT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] sreg_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  total_cnt_r;
    logic              head_r;
    logic              pce_r;
    logic              rb_valid_r;
    logic              rb_bit_r;
    logic              busy_r;
    logic              done_r;

    logic [BIT_W-1:0]  bit_cnt_nxt_s;
    logic [CNT_W-1:0]  total_cnt_nxt_s;
    logic              last_bit_s;
    logic              word_end_s;

    // Post-increment counter values used to decide the SHIFT exit.
    always_comb begin
        bit_cnt_nxt_s   = bit_cnt_r + BIT_W'(1);
        total_cnt_nxt_s = total_cnt_r + CNT_W'(1);
        last_bit_s      = (total_cnt_nxt_s == CNT_W'(CHAIN_LEN));
        word_end_s      = (bit_cnt_nxt_s == BIT_W'(WORD_W));
    end

    // Ready is a pure decode of the state register, so it carries no input path.
    assign word_ready  = (state_r == ST_FETCH);
    assign ccff_head   = head_r;
    assign prog_clk_en = pce_r;
    assign rb_valid    = rb_valid_r;
    assign rb_bit      = rb_bit_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Load sequencer: fetch a word, shift it out, repeat until the chain is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            sreg_r      <= {WORD_W{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            total_cnt_r <= {CNT_W{1'b0}};
            head_r      <= 1'b0;
            pce_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pce_r  <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_FETCH;
                        total_cnt_r <= {CNT_W{1'b0}};
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // No shift while waiting, so backpressure never costs chain bits.
                    pce_r  <= 1'b0;
                    done_r <= 1'b0;
                    busy_r <= 1'b1;
                    if (word_valid) begin
                        sreg_r    <= word_data;
                        bit_cnt_r <= {BIT_W{1'b0}};
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    head_r      <= sreg_r[0];
                    pce_r       <= 1'b1;
                    sreg_r      <= sreg_r >> 1'b1;
                    bit_cnt_r   <= bit_cnt_nxt_s;
                    total_cnt_r <= total_cnt_nxt_s;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b1;
                    // Chain-full wins over word-end: leftover high bits of a
                    // partial last word are simply dropped.
                    if (last_bit_s) begin
                        state_r <= ST_DONE;
                    end else if (word_end_s) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // The final shift happens on this edge; done lines up with it.
                    pce_r   <= 1'b0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    pce_r   <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the chain tail on every edge that actually shifts the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_valid_r <= 1'b0;
            rb_bit_r   <= 1'b0;
        end else if (pce_r) begin
            rb_valid_r <= 1'b1;
            rb_bit_r   <= ccff_tail;
        end else begin
            rb_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 16-bit chain instance with a behavioural
// chain model on its head/tail pins, plus a 12-bit chain instance for the
// partial-last-word case. Drivers queue expected head/readback bits; monitors
// pop and compare whenever the DUT presents a shift or readback bit.
module tb_ccff_chain_loader;

    logic clk;
    logic reset_n;

    // 16-bit chain instance
    logic       a_start, a_valid, a_ready, a_head, a_pce, a_tail, a_rbv, a_rbb, a_busy, a_done;
    logic [7:0] a_data;
    logic [15:0] chain_q;

    // 12-bit chain instance
    logic       b_start, b_valid, b_ready, b_head, b_pce, b_tail, b_rbv, b_rbb, b_busy, b_done;
    logic [7:0] b_data;

    int checks = 0;
    int errors = 0;

    bit a_hq[$];
    bit a_rq[$];
    bit b_hq[$];

    int cyc        = 0;
    int a_pce_cnt  = 0;
    int a_done_cnt = 0;
    int a_first    = -1;
    int a_last     = -1;
    int b_pce_cnt  = 0;
    int b_done_cnt = 0;
    int b_hs_cnt   = 0;

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .word_valid(a_valid),
        .word_data(a_data), .word_ready(a_ready), .ccff_head(a_head),
        .prog_clk_en(a_pce), .ccff_tail(a_tail), .rb_valid(a_rbv),
        .rb_bit(a_rbb), .busy(a_busy), .done(a_done)
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .word_valid(b_valid),
        .word_data(b_data), .word_ready(b_ready), .ccff_head(b_head),
        .prog_clk_en(b_pce), .ccff_tail(b_tail), .rb_valid(b_rbv),
        .rb_bit(b_rbb), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: head enters at bit 0, the oldest bit sits at the tail.
    assign a_tail = chain_q[15];
    assign b_tail = 1'b0;
    always @(posedge clk) begin
        if (a_pce) chain_q <= {chain_q[14:0], a_head};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (a_pce) begin
                a_pce_cnt++;
                if (a_first < 0) a_first = cyc;
                a_last = cyc;
                if (a_hq.size() == 0) fail_now("a_head_unexpected_shift");
                else chk("a_head", a_head, a_hq.pop_front());
            end
            if (a_rbv) begin
                if (a_rq.size() == 0) fail_now("a_rb_unexpected");
                else chk("a_rb_bit", a_rbb, a_rq.pop_front());
            end
            if (a_done) begin
                a_done_cnt++;
                chk("a_done_with_last_rb", a_rbv, 1);
            end
        end
    end

    // Monitor for the 12-bit instance
    always @(negedge clk) begin
        if (reset_n) begin
            if (b_pce) begin
                b_pce_cnt++;
                if (b_hq.size() == 0) fail_now("b_head_unexpected_shift");
                else chk("b_head", b_head, b_hq.pop_front());
            end
            if (b_ready && b_valid) b_hs_cnt++;
            if (b_done) b_done_cnt++;
        end
    end

    task automatic push_a(input logic [7:0] w0, input logic [7:0] w1, input logic [15:0] rb);
        for (int i = 0; i < 8; i++) a_hq.push_back(w0[i]);
        for (int i = 0; i < 8; i++) a_hq.push_back(w1[i]);
        for (int i = 15; i >= 0; i--) a_rq.push_back(rb[i]);
        a_pce_cnt = 0;
        a_first   = -1;
        a_last    = -1;
    endtask

    task automatic start_a();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] w);
        int t = 0;
        a_valid = 1'b1;
        a_data  = w;
        while (!a_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("a_word_ready_timeout");
        @(negedge clk);
    endtask

    task automatic wait_done_a(input int d0);
        int t = 0;
        while (a_done_cnt == d0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("a_done_timeout");
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_load_end_a(input int d0);
        chk("a_shift_count", a_pce_cnt, 16);
        chk("a_done_count", a_done_cnt, d0 + 1);
        chk("a_busy_after_done", a_busy, 0);
        chk("a_done_single_cycle", a_done, 0);
        chk("a_head_queue_drained", a_hq.size(), 0);
        chk("a_rb_queue_drained", a_rq.size(), 0);
    endtask

    initial begin
        int d0;
        int t;
        reset_n = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        chain_q = 16'hFFFF;

        #12;
        chk("rst_word_ready", a_ready, 0);
        chk("rst_ccff_head", a_head, 0);
        chk("rst_prog_clk_en", a_pce, 0);
        chk("rst_rb_valid", a_rbv, 0);
        chk("rst_rb_bit", a_rbb, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Load 1: A5, 3C with valid held high; chain preloaded to all ones.
        push_a(8'hA5, 8'h3C, 16'hFFFF);
        d0 = a_done_cnt;
        start_a();
        chk("a_busy_after_start", a_busy, 1);
        send_a(8'hA5);
        send_a(8'h3C);
        a_valid = 1'b0;
        wait_done_a(d0);
        check_load_end_a(d0);
        chk("a_one_bubble_span", a_last - a_first, 16);

        // Load 2: zeros with a 5-cycle stall and a stray start; readback returns load 1.
        push_a(8'h00, 8'h00, 16'hA53C);
        d0 = a_done_cnt;
        start_a();
        send_a(8'h00);
        a_valid = 1'b0;
        t = 0;
        while (!a_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("a_stall_ready_timeout");
        for (int i = 1; i <= 5; i++) begin
            if (i >= 2) chk("a_stall_pce", a_pce, 0);
            if (i >= 3) chk("a_stall_rb_valid", a_rbv, 0);
            if (i == 3) a_start = 1'b1;
            if (i == 4) a_start = 1'b0;
            @(negedge clk);
        end
        send_a(8'h00);
        a_valid = 1'b0;
        wait_done_a(d0);
        check_load_end_a(d0);
        repeat (3) @(negedge clk);
        chk("a_stray_start_ignored", a_busy, 0);

        // Load 3: aborted by reset after five shifts of F0.
        push_a(8'hF0, 8'h00, 16'h0000);
        d0 = a_done_cnt;
        start_a();
        send_a(8'hF0);
        a_valid = 1'b0;
        t = 0;
        while (a_pce_cnt < 5 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) fail_now("a_five_shift_timeout");
        reset_n = 1'b0;
        #1;
        chk("abort_word_ready", a_ready, 0);
        chk("abort_ccff_head", a_head, 0);
        chk("abort_prog_clk_en", a_pce, 0);
        chk("abort_rb_valid", a_rbv, 0);
        chk("abort_rb_bit", a_rbb, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        a_hq.delete();
        a_rq.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", a_done_cnt, d0);
        reset_n = 1'b1;

        // Load 4: restarts from bit 0; readback shows the five aborted bits last.
        push_a(8'h5A, 8'hC3, 16'h0001);
        d0 = a_done_cnt;
        start_a();
        send_a(8'h5A);
        send_a(8'hC3);
        a_valid = 1'b0;
        wait_done_a(d0);
        check_load_end_a(d0);

        // 12-bit chain: FF then 05, valid kept high past the end.
        for (int i = 0; i < 8; i++) b_hq.push_back(1'b1);
        b_hq.push_back(1'b1); b_hq.push_back(1'b0);
        b_hq.push_back(1'b1); b_hq.push_back(1'b0);
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_valid = 1'b1;
        b_data  = 8'hFF;
        t = 0;
        while (b_hs_cnt < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        b_data = 8'h05;
        while (b_hs_cnt < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        b_data = 8'hEE;
        while (b_done_cnt < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("b_done_timeout");
        repeat (4) @(negedge clk);
        b_valid = 1'b0;
        chk("b_shift_count", b_pce_cnt, 12);
        chk("b_handshakes", b_hs_cnt, 2);
        chk("b_done_count", b_done_cnt, 1);
        chk("b_busy_after_done", b_busy, 0);
        chk("b_head_queue_drained", b_hq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

endmodule
